// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types: operand source, control bundle, scoreboard entry and forwarding source.
// Imported by the hazard scoreboard and its per-register entry.
package pipes;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_PC   = 2'd2,
        SRC_ZERO = 2'd3
    } src_t;

    typedef struct packed {
        logic       wen;
        src_t       a_src;
        src_t       b_src;
        logic [2:0] lat;
    } supercontrol_t;

    // Widest countdown any scoreboard instance may use; narrower counts are zero-extended.
    localparam int SB_CNT_W = 8;

    typedef struct packed {
        logic                busy;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

    typedef enum logic {
        FWD_SRC_RF  = 1'b0,
        FWD_SRC_NET = 1'b1
    } fwd_src_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One architectural register's scoreboard state: busy flag plus cycles until its result can be forwarded.
module sb_entry
    import pipes::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             clr,
    input  logic [LAT_W-1:0] lat,
    output sb_entry_t        entry
);

    logic             busy_q;
    logic [LAT_W-1:0] cnt_q;

    // A new writer outranks a retiring one, so set is checked before clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (set) begin
            busy_q <= 1'b1;
            cnt_q  <= lat;
        end else if (clr) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (busy_q && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign entry.busy = busy_q;
    assign entry.cnt  = SB_CNT_W'(cnt_q);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard with forwarding select.
// Define HAZARD_PERF_EN to build the 64-bit stall-cycle performance counter.
module hazard_scoreboard
    import pipes::*;
#(
    parameter int NREG  = 32,
    parameter int NSRC  = 2,
    parameter int LAT_W = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_dst,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic [NSRC*AW-1:0]  issue_ra,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_dst,
    output logic                stall,
    output logic [NSRC-1:0]     fwd_sel,
    output logic [NREG-1:0]     busy_vec,
    output logic [63:0]         stall_cycles
);

    sb_entry_t       entries [NREG];
    logic [NREG-1:0] pending;
    logic            accept_wr;
    logic            raw;
    logic            waw;

    // Register 0 is hardwired zero and never tracked.
    assign entries[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk   (clk),
            .reset (reset),
            .set   (accept_wr && (issue_dst == AW'(r))),
            .clr   (wb_valid && (wb_dst == AW'(r))),
            .lat   (issue_lat),
            .entry (entries[r])
        );
    end

    always_comb begin
        busy_vec = '0;
        pending  = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = entries[r].busy;
            pending[r]  = entries[r].busy && (entries[r].cnt != '0);
        end
    end

    // A pending register that retires this cycle no longer blocks; forwarding looks at pre-clear state.
    always_comb begin
        logic [AW-1:0] ra;
        fwd_src_t      src;
        raw     = 1'b0;
        fwd_sel = '0;
        ra      = '0;
        src     = FWD_SRC_RF;
        for (int i = 0; i < NSRC; i++) begin
            ra  = issue_ra[i*AW +: AW];
            src = FWD_SRC_RF;
            if ((ra != '0) && pending[ra] && !(wb_valid && (wb_dst == ra))) begin
                raw = 1'b1;
            end
            if ((ra != '0) && busy_vec[ra] && !pending[ra]) begin
                src = FWD_SRC_NET;
            end
            fwd_sel[i] = (src == FWD_SRC_NET);
        end
    end

    assign waw = issue_wen && (issue_dst != '0) && pending[issue_dst]
                 && !(wb_valid && (wb_dst == issue_dst));

    assign stall     = issue_valid && (raw || waw);
    assign accept_wr = issue_valid && !stall && issue_wen && (issue_dst != '0);

`ifdef HAZARD_PERF_EN
    logic [63:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 64'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard using immediate assertions.
module tb_hazard_scoreboard;

    localparam int NREG  = 32;
    localparam int NSRC  = 2;
    localparam int LAT_W = 3;
    localparam int AW    = $clog2(NREG);

`ifdef HAZARD_PERF_EN
    localparam logic [63:0] PERF_STALLS_032 = 64'd2;
`else
    localparam logic [63:0] PERF_STALLS_032 = 64'd0;
`endif

    logic               clk;
    logic               reset;
    logic               issue_valid;
    logic               issue_wen;
    logic [AW-1:0]      issue_dst;
    logic [LAT_W-1:0]   issue_lat;
    logic [NSRC*AW-1:0] issue_ra;
    logic               wb_valid;
    logic [AW-1:0]      wb_dst;
    logic               stall;
    logic [NSRC-1:0]    fwd_sel;
    logic [NREG-1:0]    busy_vec;
    logic [63:0]        stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .LAT_W(LAT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .issue_ra     (issue_ra),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_dst   = '0;
        issue_lat   = '0;
        issue_ra    = '0;
        wb_valid    = 1'b0;
        wb_dst      = '0;
    endtask

    task automatic drive_issue(input logic wen, input int dst, input int lat, input int ra0, input int ra1);
        issue_valid = 1'b1;
        issue_wen   = wen;
        issue_dst   = AW'(dst);
        issue_lat   = LAT_W'(lat);
        issue_ra    = {AW'(ra1), AW'(ra0)};
    endtask

    task automatic drive_wb(input int dst);
        wb_valid = 1'b1;
        wb_dst   = AW'(dst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        sample();
        check("rst_busy_vec", 64'(busy_vec), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_fwd_sel", 64'(fwd_sel), 64'd0);
        check("rst_stall_cycles", stall_cycles, 64'd0);

        // Producer x5 lat=2, dependent reader stalls two cycles then forwards.
        tick();
        drive_issue(1'b1, 5, 2, 0, 0);
        sample();
        check("raw_producer_accept", 64'(stall), 64'd0);
        tick();
        drive_issue(1'b0, 0, 0, 5, 0);
        sample();
        check("raw_busy5", 64'(busy_vec[5]), 64'd1);
        check("raw_stall_c1", 64'(stall), 64'd1);
        check("raw_fwd_c1", 64'(fwd_sel), 64'd0);
        tick();
        sample();
        check("raw_stall_c2", 64'(stall), 64'd1);
        tick();
        sample();
        check("raw_stall_c3", 64'(stall), 64'd0);
        check("raw_fwd_c3", 64'(fwd_sel), 64'd1);
        tick();
        idle();
        sample();
        check("raw_stall_cycles", stall_cycles, PERF_STALLS_032);
        drive_wb(5);
        tick();
        idle();
        sample();
        check("raw_wb_clear", 64'(busy_vec), 64'd0);

        // Writes to x0 are never tracked.
        tick();
        drive_issue(1'b1, 0, 3, 0, 0);
        tick();
        drive_issue(1'b0, 0, 0, 0, 0);
        sample();
        check("x0_busy_vec", 64'(busy_vec), 64'd0);
        check("x0_stall", 64'(stall), 64'd0);
        check("x0_fwd_sel", 64'(fwd_sel), 64'd0);

        // x7 ready, then retire and re-issue x7 in the same cycle: new writer wins.
        tick();
        drive_issue(1'b1, 7, 0, 0, 0);
        tick();
        drive_issue(1'b0, 0, 0, 0, 7);
        sample();
        check("x7_fwd_ready", 64'(fwd_sel), 64'd2);
        check("x7_no_stall_ready", 64'(stall), 64'd0);
        drive_issue(1'b1, 7, 1, 0, 0);
        drive_wb(7);
        sample();
        check("x7_same_cycle_accept", 64'(stall), 64'd0);
        tick();
        idle();
        drive_issue(1'b0, 0, 0, 7, 0);
        sample();
        check("x7_busy_after_race", 64'(busy_vec[7]), 64'd1);
        check("x7_reader_stall", 64'(stall), 64'd1);
        tick();
        sample();
        check("x7_reader_go", 64'(stall), 64'd0);
        check("x7_reader_fwd", 64'(fwd_sel), 64'd1);
        tick();
        idle();
        drive_wb(7);
        tick();
        idle();

        // WAW on x3: second writer waits until the first countdown reaches 0.
        drive_issue(1'b1, 3, 2, 0, 0);
        tick();
        drive_issue(1'b1, 3, 1, 0, 0);
        sample();
        check("waw_stall_c1", 64'(stall), 64'd1);
        tick();
        sample();
        check("waw_stall_c2", 64'(stall), 64'd1);
        tick();
        sample();
        check("waw_accept", 64'(stall), 64'd0);
        tick();
        drive_issue(1'b0, 0, 0, 3, 0);
        sample();
        check("waw_new_cnt_stall", 64'(stall), 64'd1);
        tick();
        sample();
        check("waw_new_cnt_fwd", 64'(fwd_sel), 64'd1);
        check("waw_new_cnt_go", 64'(stall), 64'd0);
        tick();
        idle();

        // Reset overrides busy state and a concurrent accept.
        drive_issue(1'b1, 4, 3, 0, 0);
        tick();
        drive_issue(1'b1, 9, 3, 0, 0);
        tick();
        idle();
        sample();
        check("rst2_busy_pre", 64'({busy_vec[9], busy_vec[4]}), 64'd3);
        drive_issue(1'b1, 10, 2, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        drive_issue(1'b0, 0, 0, 4, 9);
        sample();
        check("rst2_busy_vec", 64'(busy_vec), 64'd0);
        check("rst2_stall_cycles", stall_cycles, 64'd0);
        check("rst2_stall", 64'(stall), 64'd0);
        check("rst2_fwd_sel", 64'(fwd_sel), 64'd0);
        tick();
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
